seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_pkg.sv | 16 +
 rtl/hex_to_seg7.sv | 13 +
 rtl/seg7_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 8-digit seven-segment scan driver.
// Holds the digit count, the dark pattern and the hex-to-segment table.
package seg7_pkg;

  localparam int unsigned DIGITS = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low g..a patterns, indexed by hex digit (entry 15 listed first).
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex digit + dp to active-low segment pattern.
// Ports: hex_i[3:0] digit, dp_i decimal point on, seg_o[7:0] {~dp, g..a}.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = {~dp_i, SEG_LUT[hex_i]};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit seven-segment scanner with tear-free shadow load.
// Ports: clk, rst_n, enable, load, data_in[31:0], dp_in[7:0] in; num[2:0],
// seg[7:0], pending, frame_done out. Define SCAN_BLANK_EN for slot blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  output logic [2:0]  num,
  output logic [7:0]  seg,
  output logic        pending,
  output logic        frame_done
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] TC = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK_CNT = DW'(BLANK_CYCLES);

`ifdef SCAN_BLANK_EN
  localparam logic BLANK_ON = 1'b1;
`else
  localparam logic BLANK_ON = 1'b0;
`endif

  logic [DW-1:0]       div_q, div_d;
  logic [2:0]          num_q, num_d;
  logic [7:0]          seg_q, seg_d;
  logic                pend_q, pend_d;
  logic                fd_q, fd_d;
  logic [DIGITS*4-1:0] shd_data_q, shd_data_d;
  logic [DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic [DIGITS*4-1:0] dsp_data_q, dsp_data_d;
  logic [DIGITS-1:0]   dsp_dp_q, dsp_dp_d;

  logic       tc;
  logic       wrap;
  logic       blank;
  logic [3:0] cur_hex;
  logic       cur_dp;
  logic [7:0] cur_pat;

  assign tc   = (div_q == TC);
  assign wrap = enable && tc && (num_q == 3'd7);

  always_comb begin
    div_d      = div_q;
    num_d      = num_q;
    pend_d     = pend_q;
    fd_d       = 1'b0;
    shd_data_d = shd_data_q;
    shd_dp_d   = shd_dp_q;
    dsp_data_d = dsp_data_q;
    dsp_dp_d   = dsp_dp_q;
    if (!enable) begin
      div_d  = '0;
      num_d  = 3'd0;
      pend_d = 1'b0;
      if (load) begin
        dsp_data_d = data_in;
        dsp_dp_d   = dp_in;
      end else if (pend_q) begin
        dsp_data_d = shd_data_q;
        dsp_dp_d   = shd_dp_q;
      end
    end else begin
      if (tc) begin
        div_d = '0;
        num_d = num_q + 3'd1;
      end else begin
        div_d = div_q + DW'(1);
      end
      if (wrap) begin
        fd_d   = 1'b1;
        pend_d = 1'b0;
        // A load on the commit edge beats the older shadow.
        if (load) begin
          dsp_data_d = data_in;
          dsp_dp_d   = dp_in;
        end else if (pend_q) begin
          dsp_data_d = shd_data_q;
          dsp_dp_d   = shd_dp_q;
        end
      end else if (load) begin
        shd_data_d = data_in;
        shd_dp_d   = dp_in;
        pend_d     = 1'b1;
      end
    end
  end

  // Pattern built from next-state values so num and seg change together.
  assign cur_hex = dsp_data_d[{num_d, 2'b00} +: 4];
  assign cur_dp  = dsp_dp_d[num_d];
  assign blank   = BLANK_ON && (div_d < BLANK_CNT);

  hex_to_seg7 u_dec (
    .hex_i (cur_hex),
    .dp_i  (cur_dp),
    .seg_o (cur_pat)
  );

  assign seg_d = (!enable || blank) ? SEG_OFF : cur_pat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      num_q      <= 3'd0;
      seg_q      <= SEG_OFF;
      pend_q     <= 1'b0;
      fd_q       <= 1'b0;
      shd_data_q <= '0;
      shd_dp_q   <= '0;
      dsp_data_q <= '0;
      dsp_dp_q   <= '0;
    end else begin
      div_q      <= div_d;
      num_q      <= num_d;
      seg_q      <= seg_d;
      pend_q     <= pend_d;
      fd_q       <= fd_d;
      shd_data_q <= shd_data_d;
      shd_dp_q   <= shd_dp_d;
      dsp_data_q <= dsp_data_d;
      dsp_dp_q   <= dsp_dp_d;
    end
  end

  assign num        = num_q;
  assign seg        = seg_q;
  assign pending    = pend_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboard bench for seg7_scan_ctrl.
// Reference model tracks enabled-cycle count; SCAN_DIV=4, BLANK_CYCLES=1.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in = '0;
  logic [2:0]  num;
  logic [7:0]  seg;
  logic        pending;
  logic        frame_done;

  seg7_scan_ctrl #(
    .SCAN_DIV     (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .num        (num),
    .seg        (seg),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [12:0] expq[$];
  bit started = 1'b0;

  logic [6:0] lut [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int          en_cnt = 0;
  logic [31:0] m_data = '0;
  logic [7:0]  m_dp = '0;
  logic [31:0] s_data = '0;
  logic [7:0]  s_dp = '0;
  bit          m_pend = 1'b0;

  function automatic int mnum();
    return (en_cnt / 4) % 8;
  endfunction

  // Expected {num, seg, pending, frame_done} after this clock edge.
  function automatic logic [12:0] model();
    logic [2:0]  n;
    logic        w;
    logic [31:0] d;
    if (!rst_n) begin
      en_cnt = 0;
      m_data = '0;
      m_dp = '0;
      s_data = '0;
      s_dp = '0;
      m_pend = 1'b0;
      return {3'd0, 8'hFF, 1'b0, 1'b0};
    end
    if (!enable) begin
      en_cnt = 0;
      if (load) begin
        m_data = data_in;
        m_dp = dp_in;
      end else if (m_pend) begin
        m_data = s_data;
        m_dp = s_dp;
      end
      m_pend = 1'b0;
      return {3'd0, 8'hFF, 1'b0, 1'b0};
    end
    en_cnt++;
    n = 3'(mnum());
    w = (en_cnt % 32) == 0;
    if (w) begin
      if (load) begin
        m_data = data_in;
        m_dp = dp_in;
      end else if (m_pend) begin
        m_data = s_data;
        m_dp = s_dp;
      end
      m_pend = 1'b0;
    end else if (load) begin
      s_data = data_in;
      s_dp = dp_in;
      m_pend = 1'b1;
    end
    d = m_data >> (4 * n);
    return {n, ~m_dp[n], lut[d[3:0]], m_pend, w};
  endfunction

  task automatic cyc(input logic rn, input logic en, input logic ld,
                     input logic [31:0] d, input logic [7:0] p);
    @(negedge clk);
    rst_n = rn;
    enable = en;
    load = ld;
    data_in = d;
    dp_in = p;
    @(posedge clk);
    expq.push_back(model());
    started = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic to_num(input int n);
    for (int i = 0; i < 64 && mnum() != n; i++) idle(1);
    vectors++;
    if (mnum() != n) begin
      miscompares++;
      $display("FAIL to_num got %0d want %0d", mnum(), n);
    end
  endtask

  initial begin : monitor
    logic [12:0] e;
    logic [12:0] got;
    forever begin
      @(posedge clk);
      #2;
      if (started) begin
        vectors++;
        got = {num, seg, pending, frame_done};
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL queue_empty t=%0t got=%h", $time, got);
        end else begin
          e = expq.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL scan t=%0t got num=%0d seg=%h pend=%b fd=%b want num=%0d seg=%h pend=%b fd=%b",
                     $time, got[12:10], got[9:2], got[1], got[0],
                     e[12:10], e[9:2], e[1], e[0]);
          end
        end
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, 1'b1, 32'h76543210, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    idle(70);
    to_num(3);
    cyc(1'b1, 1'b1, 1'b1, 32'hFEDCBA98, 8'h00);
    idle(40);
    to_num(2);
    cyc(1'b1, 1'b1, 1'b1, 32'h22222222, 8'hFF);
    for (int i = 0; i < 64 && ((en_cnt + 1) % 32) != 0; i++) idle(1);
    cyc(1'b1, 1'b1, 1'b1, 32'h11111111, 8'h04);
    idle(40);
    to_num(1);
    cyc(1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 8'h81);
    to_num(5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({num, seg, pending, frame_done} !== {3'd0, 8'hFF, 2'b00}) begin
      miscompares++;
      $display("FAIL async_reset got num=%0d seg=%h pend=%b fd=%b want 0 FF 0 0",
               num, seg, pending, frame_done);
    end
    @(posedge clk);
    expq.push_back(model());
    cyc(1'b0, 1'b1, 1'b0, '0, '0);
    cyc(1'b1, 1'b1, 1'b0, '0, '0);
    idle(40);
    for (int i = 0; i < 800; i++) begin
      cyc(1'b1, $urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0,
          $urandom, 8'($urandom));
    end
    @(negedge clk);
    started = 1'b0;
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL leftover got %0d want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
